// File: rtl/contador_pkg.sv
// Shared definitions for the counter controller: state encoding and default width.
package contador_pkg;

    localparam int WIDTH_DEF = 3;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        HOLD = ST_HOLD,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/contador_core.sv
// Parallel-load up/down counter; load wins over enable.
module contador_core
    import contador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             load,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Counter register: load a new value, or step one in the requested direction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= dir ? q + WIDTH'(1) : q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/controlador_contador.sv
// Sequencing controller: FSM, prescaler, start-time latches and tc/done generation
// around a loadable up/down counter core.
module controlador_contador
    import contador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             up,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_t           state, state_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic             dir_q, dir_nxt;
    logic             mode_q, mode_nxt;
    logic [WIDTH-1:0] limit_q, limit_nxt;
    logic             tc_q, tc_nxt;

    logic             core_en;
    logic             core_load;
    logic             core_dir;
    logic [WIDTH-1:0] core_d;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] step_val;

    assign target   = dir_q ? limit_q : '0;
    assign step_val = dir_q ? count + WIDTH'(1) : count - WIDTH'(1);

    contador_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rstn (rstn),
        .en   (core_en),
        .load (core_load),
        .dir  (core_dir),
        .d    (core_d),
        .q    (count)
    );

    // Controller registers: state, prescaler, run parameters and the tc pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            presc   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            limit_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            dir_q   <= dir_nxt;
            mode_q  <= mode_nxt;
            limit_q <= limit_nxt;
            tc_q    <= tc_nxt;
        end
    end

    // Next-state logic; HOLD with pause released counts as an active cycle so a
    // pause of P cycles shifts everything by exactly P.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        dir_nxt   = dir_q;
        mode_nxt  = mode_q;
        limit_nxt = limit_q;
        tc_nxt    = 1'b0;
        core_en   = 1'b0;
        core_load = 1'b0;
        core_dir  = dir_q;
        core_d    = dir_q ? '0 : limit_q;

        case (state)
            IDLE: begin
                if (start) begin
                    if (limit != '0) begin
                        dir_nxt   = up;
                        mode_nxt  = mode;
                        limit_nxt = limit;
                        core_load = 1'b1;
                        core_d    = up ? '0 : limit;
                        presc_nxt = '0;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN, HOLD: begin
                if (stop) begin
                    presc_nxt = '0;
                    state_nxt = IDLE;
                end else if (pause) begin
                    state_nxt = HOLD;
                end else begin
                    state_nxt = RUN;
                    if (presc == PRESC_LAST) begin
                        presc_nxt = '0;
                        if (count == target) begin
                            core_load = 1'b1;
                        end else begin
                            core_en = 1'b1;
                            if (step_val == target) begin
                                tc_nxt = 1'b1;
                                if (!mode_q) begin
                                    state_nxt = DONE;
                                end
                            end
                        end
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN) || (state == HOLD);
    assign done = (state == DONE);
    assign tc   = tc_q;

endmodule

// File: tb/tb_controlador_contador.sv
// Self-checking bench: two controllers (DIV=1 and DIV=2) share stimulus and are
// compared every cycle against an elapsed-time arithmetic model.
module tb_controlador_contador;

    logic       clk;
    logic       rstn;
    logic       start, stop, pause, up, mode;
    logic [2:0] limit;

    logic [2:0] count1, count2;
    logic       busy1, busy2, tc1, tc2, done1, done2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int st;
        int t;
        int lim;
        bit up;
        bit cont;
        int count;
        bit tc;
    } mdl_t;

    mdl_t m1, m2;

    controlador_contador #(.WIDTH(3), .DIV(1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pause(pause),
        .up(up), .mode(mode), .limit(limit),
        .count(count1), .busy(busy1), .tc(tc1), .done(done1)
    );

    controlador_contador #(.WIDTH(3), .DIV(2)) dut2 (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pause(pause),
        .up(up), .mode(mode), .limit(limit),
        .count(count2), .busy(busy2), .tc(tc2), .done(done2)
    );

    initial clk = 1'b0;
    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit sp, input bit p, input bit u,
                                 input bit m, input int l);
        start = s;
        stop  = sp;
        pause = p;
        up    = u;
        mode  = m;
        limit = 3'(l);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic modelReset(output mdl_t m);
        m.st    = 0;
        m.t     = 0;
        m.lim   = 0;
        m.up    = 1'b0;
        m.cont  = 1'b0;
        m.count = 0;
        m.tc    = 1'b0;
    endtask

    // Count position follows from the number of active cycles since start.
    task automatic modelStep(inout mdl_t m, input int div);
        int steps;
        int pos;
        m.tc = 1'b0;
        case (m.st)
            0: begin
                if (start) begin
                    if (limit != 0) begin
                        m.lim   = int'(limit);
                        m.up    = up;
                        m.cont  = mode;
                        m.t     = 0;
                        m.count = up ? 0 : int'(limit);
                        m.st    = 1;
                    end else begin
                        m.st = 2;
                    end
                end
            end
            1: begin
                if (stop) begin
                    m.st = 0;
                end else if (!pause) begin
                    m.t++;
                    if (m.t % div == 0) begin
                        steps = m.t / div;
                        if (m.cont) begin
                            pos     = steps % (m.lim + 1);
                            m.count = m.up ? pos : m.lim - pos;
                            m.tc    = (pos == m.lim);
                        end else begin
                            m.count = m.up ? steps : m.lim - steps;
                            m.tc    = (steps == m.lim);
                            if (steps == m.lim) m.st = 2;
                        end
                    end
                end
            end
            default: m.st = 0;
        endcase
    endtask

    // Reference model advances on each clock edge and clears on reset.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            modelReset(m1);
            modelReset(m2);
        end else begin
            modelStep(m1, 1);
            modelStep(m2, 2);
        end
    end

    // Every-cycle comparison of both controllers against the model.
    always @(posedge clk or negedge rstn) begin
        #1;
        checkOutput("d1_count", int'(count1), m1.count);
        checkOutput("d1_busy",  int'(busy1),  int'(m1.st == 1));
        checkOutput("d1_tc",    int'(tc1),    int'(m1.tc));
        checkOutput("d1_done",  int'(done1),  int'(m1.st == 2));
        checkOutput("d2_count", int'(count2), m2.count);
        checkOutput("d2_busy",  int'(busy2),  int'(m2.st == 1));
        checkOutput("d2_tc",    int'(tc2),    int'(m2.tc));
        checkOutput("d2_done",  int'(done2),  int'(m2.st == 2));
    end

    task automatic waitIdle();
        for (int i = 0; i < 100; i++) begin
            if (!busy1 && !busy2 && !done1 && !done2) break;
            tick();
        end
        checkOutput("wait_idle", int'(busy1 | busy2), 0);
    endtask

    initial begin
        int tc_seen;
        int found;

        rstn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("rst_count", int'(count1), 0);
        checkOutput("rst_busy",  int'(busy1),  0);
        checkOutput("rst_done",  int'(done1),  0);
        rstn = 1'b1;
        tick();

        // One-shot up, limit 5
        applyStimulus(1, 0, 0, 1, 0, 5);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 5);
        checkOutput("os_count0", int'(count1), 0);
        checkOutput("os_busy0",  int'(busy1),  1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput("os_count", int'(count1), k);
            checkOutput("os_tc",    int'(tc1),    (k == 5) ? 1 : 0);
            checkOutput("os_done",  int'(done1),  (k == 5) ? 1 : 0);
            checkOutput("os_busy",  int'(busy1),  (k == 5) ? 0 : 1);
        end
        tick();
        checkOutput("os_idle_done", int'(done1), 0);
        waitIdle();

        // Continuous down, limit 7, observed on the DIV=2 instance
        applyStimulus(1, 0, 0, 0, 1, 7);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 7);
        tc_seen = 0;
        for (int j = 0; j < 18; j++) begin
            checkOutput("cd_count", int'(count2), (j < 16) ? 7 - j / 2 : 7);
            checkOutput("cd_done",  int'(done2), 0);
            if (j < 16 && tc2) tc_seen++;
            tick();
        end
        checkOutput("cd_tc_per_period", tc_seen, 1);
        applyStimulus(0, 1, 0, 0, 1, 7);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("cd_stopped", int'(busy1 | busy2), 0);

        // Pause at count 2 for 3 cycles, then stop+pause at count 4
        applyStimulus(1, 0, 0, 1, 0, 7);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 7);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (count1 == 3'd2) begin found = 1; break; end
            tick();
        end
        checkOutput("ps_reach2", found, 1);
        applyStimulus(0, 0, 1, 1, 0, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ps_hold_count", int'(count1), 2);
            checkOutput("ps_hold_busy",  int'(busy1),  1);
        end
        applyStimulus(0, 0, 0, 1, 0, 7);
        tick();
        checkOutput("ps_resume", int'(count1), 3);
        tick();
        checkOutput("ps_count4", int'(count1), 4);
        applyStimulus(0, 1, 1, 1, 0, 7);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 7);
        checkOutput("st_busy",  int'(busy1),  0);
        checkOutput("st_count", int'(count1), 4);
        checkOutput("st_done",  int'(done1),  0);
        tick();
        checkOutput("st_count_hold", int'(count1), 4);
        checkOutput("st_no_done",    int'(done1),  0);

        // Limit 0: immediate done, no tc, count untouched
        applyStimulus(1, 0, 0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("l0_done",  int'(done1),  1);
        checkOutput("l0_tc",    int'(tc1),    0);
        checkOutput("l0_busy",  int'(busy1),  0);
        checkOutput("l0_count", int'(count1), 4);
        tick();
        checkOutput("l0_done_end", int'(done1), 0);
        waitIdle();

        // Start while busy is ignored
        applyStimulus(1, 0, 0, 1, 0, 3);
        tick();
        applyStimulus(1, 0, 0, 0, 1, 6);
        checkOutput("sb_count0", int'(count1), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("sb_count1", int'(count1), 1);
        tick();
        checkOutput("sb_count2", int'(count1), 2);
        tick();
        checkOutput("sb_count3", int'(count1), 3);
        checkOutput("sb_done",   int'(done1),  1);
        waitIdle();

        // Limit 7 up one-shot ends at 7
        applyStimulus(1, 0, 0, 1, 0, 7);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 7);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (done1) begin found = 1; break; end
            tick();
        end
        checkOutput("l7_done_seen", found, 1);
        checkOutput("l7_count", int'(count1), 7);
        checkOutput("l7_tc",    int'(tc1),    1);
        tick();
        checkOutput("l7_count_after", int'(count1), 7);
        checkOutput("l7_busy_after",  int'(busy1),  0);
        waitIdle();

        // Asynchronous reset in the middle of a continuous run
        applyStimulus(1, 0, 0, 1, 1, 6);
        tick();
        applyStimulus(0, 0, 0, 1, 1, 6);
        tick();
        tick();
        tick();
        #2 rstn = 1'b0;
        #2;
        checkOutput("ar_count", int'(count1), 0);
        checkOutput("ar_busy",  int'(busy1),  0);
        checkOutput("ar_tc",    int'(tc1),    0);
        checkOutput("ar_done",  int'(done2),  0);
        checkOutput("ar_count2", int'(count2), 0);
        tick();
        rstn = 1'b1;
        tick();
        checkOutput("ar_idle", int'(busy1 | busy2), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1200; i++) begin
            tick();
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                          $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
